// File: rtl/flash_resp_pkg.sv
// Shared types and constants for the flash read responder.
// Optional byte masking of returned data is enabled with FLASH_RESP_BYTEMASK_EN.
package flash_resp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCEPT = 2'd2
  } state_e;

  localparam int DEF_ADDR_W      = 23;
  localparam int DEF_WAIT_STATES = 2;
  localparam int DEF_LATENCY     = 3;
  localparam int DEF_MAX_PENDING = 4;

  // Pending count must hold 0..8; wait counter must hold 0..14.
  localparam int PEND_W = 4;
  localparam int WCNT_W = 4;

  function automatic logic [31:0] byte_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/flash_resp_delay.sv
// Valid/data delay line of STAGES registers; STAGES=0 is a straight wire.
// Used to stretch the 1-cycle ROM latency up to the configured read latency.
module flash_resp_delay #(
  parameter int STAGES = 2,
  parameter int DW     = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output logic [DW-1:0] out_data
);

  generate
    if (STAGES == 0) begin : g_pass
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
      assign out_valid      = in_valid;
      assign out_data       = in_data;
    end else begin : g_pipe
      logic [STAGES-1:0] valid_q, valid_d;
      logic [DW-1:0]     data_q [STAGES];
      logic [DW-1:0]     data_d [STAGES];

      always_comb begin
        valid_d[0] = in_valid;
        data_d[0]  = in_data;
        for (int i = 1; i < STAGES; i++) begin
          valid_d[i] = valid_q[i-1];
          data_d[i]  = data_q[i-1];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_q <= '0;
          for (int i = 0; i < STAGES; i++) data_q[i] <= '0;
        end else begin
          valid_q <= valid_d;
          for (int i = 0; i < STAGES; i++) data_q[i] <= data_d[i];
        end
      end

      assign out_valid = valid_q[STAGES-1];
      assign out_data  = data_q[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/flash_read_responder.sv
// Avalon-style pipelined read responder in front of a 1-cycle synchronous ROM.
// Define FLASH_RESP_BYTEMASK_EN to zero returned bytes whose byteenable bit was 0.
module flash_read_responder
  import flash_resp_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int WAIT_STATES = DEF_WAIT_STATES,
  parameter int LATENCY     = DEF_LATENCY,
  parameter int MAX_PENDING = DEF_MAX_PENDING
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flsh_read,
  input  logic [ADDR_W-1:0] flsh_address,
  input  logic [3:0]        flsh_byteenable,
  output logic              flsh_waitrequest,
  output logic [31:0]       flsh_readdata,
  output logic              flsh_readdatavalid,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rddata,
  output logic              err_abort
);

`ifdef FLASH_RESP_BYTEMASK_EN
  localparam int DW = 36;
  logic [3:0] be_q, be_d;
`else
  localparam int DW = 32;
  logic unused_be;
  assign unused_be = ^flsh_byteenable;
`endif

  state_e              state_q, state_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic [PEND_W-1:0]   pend_q, pend_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                err_q, err_d;
  logic                rom_vld_q, rom_vld_d;
  logic                accept;
  logic                line_vld;
  logic [DW-1:0]       line_in, line_out;

  assign accept = (state_q == ST_ACCEPT);

  // Address and byteenable are captured on entry to ACCEPT, so the ROM sees the
  // address during the acceptance cycle and its data lands one cycle later.
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    addr_d    = addr_q;
    err_d     = err_q;
    rom_vld_d = accept;
`ifdef FLASH_RESP_BYTEMASK_EN
    be_d      = be_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (flsh_read && (pend_q < PEND_W'(MAX_PENDING))) begin
          if (WAIT_STATES == 0) begin
            state_d = ST_ACCEPT;
            addr_d  = flsh_address;
`ifdef FLASH_RESP_BYTEMASK_EN
            be_d    = flsh_byteenable;
`endif
          end else begin
            state_d = ST_WAIT;
            wcnt_d  = WCNT_W'(WAIT_STATES - 1);
          end
        end
      end
      ST_WAIT: begin
        if (!flsh_read) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else if (wcnt_q == '0) begin
          state_d = ST_ACCEPT;
          addr_d  = flsh_address;
`ifdef FLASH_RESP_BYTEMASK_EN
          be_d    = flsh_byteenable;
`endif
        end else begin
          wcnt_d = wcnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    pend_d = pend_q;
    if (accept && !line_vld) begin
      pend_d = pend_q + 1'b1;
    end else if (!accept && line_vld && (pend_q != '0)) begin
      pend_d = pend_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      wcnt_q    <= '0;
      pend_q    <= '0;
      addr_q    <= '0;
      err_q     <= 1'b0;
      rom_vld_q <= 1'b0;
`ifdef FLASH_RESP_BYTEMASK_EN
      be_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      pend_q    <= pend_d;
      addr_q    <= addr_d;
      err_q     <= err_d;
      rom_vld_q <= rom_vld_d;
`ifdef FLASH_RESP_BYTEMASK_EN
      be_q      <= be_d;
`endif
    end
  end

`ifdef FLASH_RESP_BYTEMASK_EN
  assign line_in = {be_q, mem_rddata};
`else
  assign line_in = mem_rddata;
`endif

  flash_resp_delay #(
    .STAGES (LATENCY - 1),
    .DW     (DW)
  ) u_delay (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (rom_vld_q),
    .in_data   (line_in),
    .out_valid (line_vld),
    .out_data  (line_out)
  );

`ifdef FLASH_RESP_BYTEMASK_EN
  assign flsh_readdata = line_vld ? (line_out[31:0] & byte_mask(line_out[35:32])) : 32'h0;
`else
  assign flsh_readdata = line_vld ? line_out : 32'h0;
`endif

  assign flsh_readdatavalid = line_vld;
  assign flsh_waitrequest   = !accept;
  assign mem_addr           = addr_q;
  assign err_abort          = err_q;

endmodule
